lsu_port_arbiter: RTL and testbench

- Shares the single cache load/store port between two requesters: requester 0 is the execute-stage memory unit, requester 1 is a secondary agent such as a future page walker or debug access.
- Both requesters use the LSU handshake. A request is valid in the cycle its `prev_stalled` is low. The response is valid in the cycle `stall_next` is low.
- Only one transaction is outstanding at a time.
- A losing request is buffered, so requesters may present a request for a single cycle only.

---
 rtl/basic_cache_params.sv | 14 +
 rtl/lsu_arb_types.sv | 29 ++
 rtl/lsu_arb_slot.sv | 43 ++++
 rtl/lsu_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/basic_cache_params.sv
// ---------------------------------------------------------------------------
// basic_cache_params
//   Cache geometry constants shared by the load/store path.
//   aligned_addr_size : width of an aligned (line) address.
//   `XLEN             : machine data width (defaults to 32 when not set by
//                       the build).
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package basic_cache_params;
   localparam int aligned_addr_size = 30;
endpackage

// File: rtl/lsu_arb_types.sv
// ---------------------------------------------------------------------------
// lsu_arb_types
//   Shared types for the LSU port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY).
//   req_id_t    : requester id, 0 = execute-stage memory unit,
//                 1 = secondary agent.
//   lsu_req_t   : one complete LSU request as held in a pending slot.
// ---------------------------------------------------------------------------
package lsu_arb_types;
   import basic_cache_params::*;

   localparam int ARB_XLEN   = `XLEN;
   localparam int ARB_MASK_W = ARB_XLEN / 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic [aligned_addr_size-1:0] addr;
      logic                         do_load;
      logic                         do_store;
      logic [ARB_XLEN-1:0]          store_data;
      logic [ARB_MASK_W-1:0]        store_mask;
   } lsu_req_t;
endpackage

// File: rtl/lsu_arb_slot.sv
// ---------------------------------------------------------------------------
// lsu_arb_slot
//   Single-entry holding register for a request that could not be issued
//   in the cycle it was presented.
//   clk, rst_n : clock, synchronous active-low reset (empties the slot).
//   load       : capture d and mark the slot full.
//   clear      : mark the slot empty (the held request has issued).
//   d          : request to capture.
//   full       : slot holds a request.
//   q          : held request (meaningful only while full).
// ---------------------------------------------------------------------------
module lsu_arb_slot
   import lsu_arb_types::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     load,
   input  logic     clear,
   input  lsu_req_t d,
   output logic     full,
   output lsu_req_t q
);

   // Load wins over clear; the arbiter never asserts both for one slot,
   // but the priority keeps a captured request from being lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

   // Payload needs no reset: it is only looked at while full is set.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/lsu_port_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_port_arbiter
//   Shares the single cache load/store port between two requesters
//   (0 = execute-stage memory unit, 1 = secondary agent). One transaction
//   is outstanding at a time; a request that cannot issue immediately is
//   held in its requester's pending slot, so requesters may present a
//   request for one cycle only.
//
//   Handshake: a request is valid in the cycle its prev_stalled is low; a
//   response is valid in the cycle stall_next is low. Neither side waits
//   for the other -- each low cycle is a complete transfer.
//
//   Ports
//     clk, rst_n                 clock, synchronous active-low reset
//     rq{0,1}_prev_stalled       low = request presented this cycle
//     rq{0,1}_addr/do_load/do_store/store_data/store_mask  request fields
//     rq{0,1}_stall_next         low = response for that requester valid
//     rq{0,1}_load_data          load data (valid with stall_next low)
//     rq{0,1}_access_fault       fault flag (valid with stall_next low)
//     lsu_prev_stalled           low = request issued to the LSU
//     lsu_addr/do_load/do_store/store_data/store_mask  issued fields
//     lsu_stall_next             low = LSU response valid
//     lsu_load_data, lsu_access_fault  LSU response fields
//     protocol_err               sticky, cleared only by reset
//     dbg_state                  current FSM state
// ---------------------------------------------------------------------------
module lsu_port_arbiter
   import lsu_arb_types::*;
#(
   // Must match the widths of lsu_req_t in lsu_arb_types.
   parameter int ADDR_W = basic_cache_params::aligned_addr_size,
   parameter int XLEN   = `XLEN,
   parameter int MASK_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              rq0_prev_stalled,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic              rq0_do_load,
   input  logic              rq0_do_store,
   input  logic [XLEN-1:0]   rq0_store_data,
   input  logic [MASK_W-1:0] rq0_store_mask,
   output logic              rq0_stall_next,
   output logic [XLEN-1:0]   rq0_load_data,
   output logic              rq0_access_fault,

   input  logic              rq1_prev_stalled,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic              rq1_do_load,
   input  logic              rq1_do_store,
   input  logic [XLEN-1:0]   rq1_store_data,
   input  logic [MASK_W-1:0] rq1_store_mask,
   output logic              rq1_stall_next,
   output logic [XLEN-1:0]   rq1_load_data,
   output logic              rq1_access_fault,

   output logic              lsu_prev_stalled,
   output logic [ADDR_W-1:0] lsu_addr,
   output logic              lsu_do_load,
   output logic              lsu_do_store,
   output logic [XLEN-1:0]   lsu_store_data,
   output logic [MASK_W-1:0] lsu_store_mask,
   input  logic              lsu_stall_next,
   input  logic [XLEN-1:0]   lsu_load_data,
   input  logic              lsu_access_fault,

   output logic              protocol_err,
   output arb_state_t        dbg_state
);

   arb_state_t state;
   req_id_t    owner;
   req_id_t    rr_ptr;

   lsu_req_t   live_req0, live_req1;
   lsu_req_t   slot_q0, slot_q1;
   lsu_req_t   cand_req0, cand_req1;
   lsu_req_t   issue_req;
   logic       slot_full0, slot_full1;
   logic       slot_load0, slot_load1;
   logic       slot_clear0, slot_clear1;

   logic       live0, live1;
   logic       cand0, cand1;
   logic       contest;
   req_id_t    grant_id;
   logic       issue;
   logic       resp;
   logic       own_wait0, own_wait1;
   logic       err_req0, err_req1;
   logic       err_idle_resp;

   assign dbg_state = state;

   // ---------------------------------------------------------------------
   // Live requests packed into the slot format
   // ---------------------------------------------------------------------
   always_comb begin
      live_req0            = '0;
      live_req0.addr       = rq0_addr;
      live_req0.do_load    = rq0_do_load;
      live_req0.do_store   = rq0_do_store;
      live_req0.store_data = rq0_store_data;
      live_req0.store_mask = rq0_store_mask;

      live_req1            = '0;
      live_req1.addr       = rq1_addr;
      live_req1.do_load    = rq1_do_load;
      live_req1.do_store   = rq1_do_store;
      live_req1.store_data = rq1_store_data;
      live_req1.store_mask = rq1_store_mask;
   end

   assign live0 = ~rq0_prev_stalled;
   assign live1 = ~rq1_prev_stalled;

   // ---------------------------------------------------------------------
   // Candidate selection and arbitration
   // ---------------------------------------------------------------------
   // A full slot always takes precedence over a live request from the same
   // requester: a live request on top of a full slot is a protocol error.
   assign cand0     = slot_full0 | live0;
   assign cand1     = slot_full1 | live1;
   assign cand_req0 = slot_full0 ? slot_q0 : live_req0;
   assign cand_req1 = slot_full1 ? slot_q1 : live_req1;

   assign contest   = cand0 & cand1;
   // Without contention the only candidate wins; with it, rr_ptr decides.
   assign grant_id  = contest ? rr_ptr : req_id_t'(cand1);

   // Gating with rst_n keeps the port quiet during the reset cycle even
   // though state has not been cleared yet.
   assign issue     = rst_n & (state == IDLE) & (cand0 | cand1);
   assign issue_req = (grant_id == 1'b1) ? cand_req1 : cand_req0;

   assign lsu_prev_stalled = ~issue;
   assign lsu_addr         = issue_req.addr;
   assign lsu_do_load      = issue_req.do_load;
   assign lsu_do_store     = issue_req.do_store;
   assign lsu_store_data   = issue_req.store_data;
   assign lsu_store_mask   = issue_req.store_mask;

   // ---------------------------------------------------------------------
   // Response routing
   // ---------------------------------------------------------------------
   assign resp = rst_n & (state == BUSY) & ~lsu_stall_next;

   assign rq0_stall_next   = ~(resp & (owner == 1'b0));
   assign rq1_stall_next   = ~(resp & (owner == 1'b1));
   assign rq0_load_data    = lsu_load_data;
   assign rq1_load_data    = lsu_load_data;
   // Fault is qualified so a non-owner never sees a stray fault flag.
   assign rq0_access_fault = lsu_access_fault & resp & (owner == 1'b0);
   assign rq1_access_fault = lsu_access_fault & resp & (owner == 1'b1);

   // ---------------------------------------------------------------------
   // Requester rule and pending slot control
   // ---------------------------------------------------------------------
   // The owner may present its next request in its own response cycle;
   // only a request while still waiting for the response is illegal.
   assign own_wait0 = (state == BUSY) & (owner == 1'b0) & lsu_stall_next;
   assign own_wait1 = (state == BUSY) & (owner == 1'b1) & lsu_stall_next;

   assign err_req0  = live0 & (slot_full0 | own_wait0);
   assign err_req1  = live1 & (slot_full1 | own_wait1);

   assign err_idle_resp = (state == IDLE) & ~lsu_stall_next;

   // Capture a legal live request unless it is the one issuing right now.
   assign slot_load0  = live0 & ~err_req0 & ~(issue & (grant_id == 1'b0));
   assign slot_load1  = live1 & ~err_req1 & ~(issue & (grant_id == 1'b1));
   assign slot_clear0 = issue & (grant_id == 1'b0) & slot_full0;
   assign slot_clear1 = issue & (grant_id == 1'b1) & slot_full1;

   lsu_arb_slot u_slot0 (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load0),
      .clear (slot_clear0),
      .d     (live_req0),
      .full  (slot_full0),
      .q     (slot_q0)
   );

   lsu_arb_slot u_slot1 (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load1),
      .clear (slot_clear1),
      .d     (live_req1),
      .full  (slot_full1),
      .q     (slot_q1)
   );

   // ---------------------------------------------------------------------
   // FSM, owner, round-robin pointer and sticky error
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= 1'b0;
         rr_ptr       <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (err_req0 | err_req1 | err_idle_resp) begin
            protocol_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (issue) begin
                  state <= BUSY;
                  owner <= grant_id;
                  // Only a contested grant moves the pointer, so an
                  // uncontested requester does not lose its next tie.
                  if (contest) begin
                     rr_ptr <= ~rr_ptr;
                  end
               end
            end
            BUSY: begin
               // Returning to IDLE here means the next issue is at least
               // one cycle after the response, with no comb path from
               // lsu_stall_next to lsu_prev_stalled.
               if (!lsu_stall_next) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_port_arbiter
//   Directed bench for lsu_port_arbiter. Inputs change 1 time unit after
//   the rising edge; outputs are sampled 3 units later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_lsu_port_arbiter;
   import lsu_arb_types::*;

   localparam int ADDR_W = basic_cache_params::aligned_addr_size;
   localparam int XLEN   = `XLEN;
   localparam int MASK_W = XLEN / 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DUT signals ----------------
   logic              rq0_prev_stalled, rq1_prev_stalled;
   logic [ADDR_W-1:0] rq0_addr, rq1_addr;
   logic              rq0_do_load, rq0_do_store, rq1_do_load, rq1_do_store;
   logic [XLEN-1:0]   rq0_store_data, rq1_store_data;
   logic [MASK_W-1:0] rq0_store_mask, rq1_store_mask;
   logic              rq0_stall_next, rq1_stall_next;
   logic [XLEN-1:0]   rq0_load_data, rq1_load_data;
   logic              rq0_access_fault, rq1_access_fault;
   logic              lsu_prev_stalled;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_do_load, lsu_do_store;
   logic [XLEN-1:0]   lsu_store_data;
   logic [MASK_W-1:0] lsu_store_mask;
   logic              lsu_stall_next;
   logic [XLEN-1:0]   lsu_load_data;
   logic              lsu_access_fault;
   logic              protocol_err;
   arb_state_t        dbg_state;

   int total = 0;
   int bad   = 0;

   lsu_port_arbiter #(
      .ADDR_W (ADDR_W),
      .XLEN   (XLEN),
      .MASK_W (MASK_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rq0_prev_stalled (rq0_prev_stalled),
      .rq0_addr         (rq0_addr),
      .rq0_do_load      (rq0_do_load),
      .rq0_do_store     (rq0_do_store),
      .rq0_store_data   (rq0_store_data),
      .rq0_store_mask   (rq0_store_mask),
      .rq0_stall_next   (rq0_stall_next),
      .rq0_load_data    (rq0_load_data),
      .rq0_access_fault (rq0_access_fault),
      .rq1_prev_stalled (rq1_prev_stalled),
      .rq1_addr         (rq1_addr),
      .rq1_do_load      (rq1_do_load),
      .rq1_do_store     (rq1_do_store),
      .rq1_store_data   (rq1_store_data),
      .rq1_store_mask   (rq1_store_mask),
      .rq1_stall_next   (rq1_stall_next),
      .rq1_load_data    (rq1_load_data),
      .rq1_access_fault (rq1_access_fault),
      .lsu_prev_stalled (lsu_prev_stalled),
      .lsu_addr         (lsu_addr),
      .lsu_do_load      (lsu_do_load),
      .lsu_do_store     (lsu_do_store),
      .lsu_store_data   (lsu_store_data),
      .lsu_store_mask   (lsu_store_mask),
      .lsu_stall_next   (lsu_stall_next),
      .lsu_load_data    (lsu_load_data),
      .lsu_access_fault (lsu_access_fault),
      .protocol_err     (protocol_err),
      .dbg_state        (dbg_state)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      rq0_prev_stalled = 1'b1;
      rq1_prev_stalled = 1'b1;
      lsu_stall_next   = 1'b1;
      lsu_access_fault = 1'b0;
   endtask

   task automatic req0(input logic [ADDR_W-1:0] a, input logic st,
                       input logic [XLEN-1:0] d, input logic [MASK_W-1:0] m);
      rq0_prev_stalled = 1'b0;
      rq0_addr         = a;
      rq0_do_load      = ~st;
      rq0_do_store     = st;
      rq0_store_data   = d;
      rq0_store_mask   = m;
   endtask

   task automatic req1(input logic [ADDR_W-1:0] a, input logic st,
                       input logic [XLEN-1:0] d, input logic [MASK_W-1:0] m);
      rq1_prev_stalled = 1'b0;
      rq1_addr         = a;
      rq1_do_load      = ~st;
      rq1_do_store     = st;
      rq1_store_data   = d;
      rq1_store_mask   = m;
   endtask

   task automatic lsu_resp(input logic [XLEN-1:0] d, input logic f);
      lsu_stall_next   = 1'b0;
      lsu_load_data    = d;
      lsu_access_fault = f;
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rq0_addr = '0; rq0_do_load = 1'b0; rq0_do_store = 1'b0;
      rq0_store_data = '0; rq0_store_mask = '0;
      rq1_addr = '0; rq1_do_load = 1'b0; rq1_do_store = 1'b0;
      rq1_store_data = '0; rq1_store_mask = '0;
      lsu_load_data = '0;
      idle_inputs();
      rst_n = 1'b0;

      // Reset state
      tick(); tick(); settle();
      chk("rst_lsu_ps", 64'(lsu_prev_stalled), 64'd1);
      chk("rst_rq0_sn", 64'(rq0_stall_next), 64'd1);
      chk("rst_rq1_sn", 64'(rq1_stall_next), 64'd1);
      chk("rst_err", 64'(protocol_err), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;

      // Single load, response 3 cycles after issue
      tick();
      req0(30'h40, 1'b0, '0, '0); settle();
      chk("t1_issue", 64'(lsu_prev_stalled), 64'd0);
      chk("t1_addr", 64'(lsu_addr), 64'h40);
      chk("t1_ld", 64'(lsu_do_load), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t1_busy_ps", 64'(lsu_prev_stalled), 64'd1);
      chk("t1_busy_st", 64'(dbg_state), 64'(BUSY));
      chk("t1_wait_sn", 64'(rq0_stall_next), 64'd1);
      tick(); tick();
      lsu_resp(32'hDEADBEEF, 1'b0); settle();
      chk("t1_rsp_sn0", 64'(rq0_stall_next), 64'd0);
      chk("t1_rsp_data", 64'(rq0_load_data), 64'hDEADBEEF);
      chk("t1_rsp_sn1", 64'(rq1_stall_next), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t1_after_sn0", 64'(rq0_stall_next), 64'd1);
      chk("t1_idle", 64'(dbg_state), 64'(IDLE));

      // Contention with rr_ptr = 0: rq0 first, rq1 held
      req0(30'h100, 1'b0, '0, '0);
      req1(30'h200, 1'b0, '0, '0); settle();
      chk("t2_win_addr", 64'(lsu_addr), 64'h100);
      tick(); idle_inputs(); settle();
      chk("t2_busy_ps", 64'(lsu_prev_stalled), 64'd1);
      tick();
      lsu_resp(32'h11111111, 1'b0); settle();
      chk("t2_rsp0_sn", 64'(rq0_stall_next), 64'd0);
      chk("t2_rsp0_d", 64'(rq0_load_data), 64'h11111111);
      chk("t2_rsp0_sn1", 64'(rq1_stall_next), 64'd1);
      chk("t2_rsp_ps", 64'(lsu_prev_stalled), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t2_slot_ps", 64'(lsu_prev_stalled), 64'd0);
      chk("t2_slot_addr", 64'(lsu_addr), 64'h200);
      tick();
      lsu_resp(32'h22222222, 1'b0); settle();
      chk("t2_rsp1_sn", 64'(rq1_stall_next), 64'd0);
      chk("t2_rsp1_d", 64'(rq1_load_data), 64'h22222222);
      chk("t2_rsp1_sn0", 64'(rq0_stall_next), 64'd1);
      tick(); idle_inputs();
      // Second tie: pointer now favours rq1
      req0(30'h300, 1'b0, '0, '0);
      req1(30'h310, 1'b0, '0, '0); settle();
      chk("t2_tie2_addr", 64'(lsu_addr), 64'h310);
      tick(); idle_inputs();
      lsu_resp(32'h33333333, 1'b0); settle();
      chk("t2_tie2_sn1", 64'(rq1_stall_next), 64'd0);
      tick(); idle_inputs(); settle();
      chk("t2_tie2_slot0", 64'(lsu_addr), 64'h300);
      chk("t2_tie2_ps", 64'(lsu_prev_stalled), 64'd0);
      tick();
      lsu_resp(32'h0, 1'b0); settle();
      chk("t2_tie2_sn0", 64'(rq0_stall_next), 64'd0);
      tick(); idle_inputs();

      // Store from rq1 presented while rq0 outstanding
      req0(30'h400, 1'b0, '0, '0); settle();
      chk("t3_issue0", 64'(lsu_addr), 64'h400);
      tick(); idle_inputs();
      req1(30'h500, 1'b1, 32'hCAFEF00D, 4'hF); settle();
      chk("t3_busy_ps", 64'(lsu_prev_stalled), 64'd1);
      tick(); idle_inputs();
      lsu_resp(32'h0, 1'b0); settle();
      chk("t3_rsp0", 64'(rq0_stall_next), 64'd0);
      tick(); idle_inputs(); settle();
      chk("t3_st_ps", 64'(lsu_prev_stalled), 64'd0);
      chk("t3_st_addr", 64'(lsu_addr), 64'h500);
      chk("t3_st_st", 64'(lsu_do_store), 64'd1);
      chk("t3_st_ld", 64'(lsu_do_load), 64'd0);
      chk("t3_st_data", 64'(lsu_store_data), 64'hCAFEF00D);
      chk("t3_st_mask", 64'(lsu_store_mask), 64'hF);
      tick();
      lsu_resp(32'h0, 1'b0); settle();
      chk("t3_rsp1", 64'(rq1_stall_next), 64'd0);
      tick(); idle_inputs(); settle();
      chk("t3_err", 64'(protocol_err), 64'd0);

      // Fault goes only to the owner
      req1(30'h600, 1'b0, '0, '0); settle();
      chk("t4_issue", 64'(lsu_addr), 64'h600);
      tick(); idle_inputs();
      lsu_resp(32'h0, 1'b1); settle();
      chk("t4_sn1", 64'(rq1_stall_next), 64'd0);
      chk("t4_f1", 64'(rq1_access_fault), 64'd1);
      chk("t4_f0", 64'(rq0_access_fault), 64'd0);
      chk("t4_sn0", 64'(rq0_stall_next), 64'd1);
      tick(); idle_inputs();
      req0(30'h700, 1'b0, '0, '0); settle();
      chk("t4_next_addr", 64'(lsu_addr), 64'h700);
      tick(); idle_inputs();
      lsu_resp(32'h44444444, 1'b0); settle();
      chk("t4_next_sn0", 64'(rq0_stall_next), 64'd0);
      chk("t4_next_f0", 64'(rq0_access_fault), 64'd0);
      chk("t4_next_d", 64'(rq0_load_data), 64'h44444444);
      tick(); idle_inputs();

      // Reset while BUSY with rq1 pending
      req0(30'h800, 1'b0, '0, '0); settle();
      tick(); idle_inputs();
      req1(30'h900, 1'b0, '0, '0); settle();
      tick(); idle_inputs();
      rst_n = 1'b0; settle();
      chk("t5_inrst_ps", 64'(lsu_prev_stalled), 64'd1);
      tick(); rst_n = 1'b1; settle();
      chk("t5_state", 64'(dbg_state), 64'(IDLE));
      chk("t5_slot_drop", 64'(lsu_prev_stalled), 64'd1);
      chk("t5_sn0", 64'(rq0_stall_next), 64'd1);
      chk("t5_sn1", 64'(rq1_stall_next), 64'd1);
      chk("t5_err0", 64'(protocol_err), 64'd0);
      lsu_resp(32'h55555555, 1'b0); settle();
      chk("t5_late_sn0", 64'(rq0_stall_next), 64'd1);
      chk("t5_late_sn1", 64'(rq1_stall_next), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t5_late_err", 64'(protocol_err), 64'd1);
      req0(30'hA00, 1'b0, '0, '0); settle();
      chk("t5_fresh_ps", 64'(lsu_prev_stalled), 64'd0);
      chk("t5_fresh_addr", 64'(lsu_addr), 64'hA00);
      tick(); idle_inputs();
      lsu_resp(32'h66666666, 1'b0); settle();
      chk("t5_fresh_sn0", 64'(rq0_stall_next), 64'd0);
      tick(); idle_inputs(); settle();
      chk("t5_sticky", 64'(protocol_err), 64'd1);
      rst_n = 1'b0;
      tick(); rst_n = 1'b1; settle();
      chk("t5_err_clr", 64'(protocol_err), 64'd0);

      // New request in the owner's own response cycle is legal
      req0(30'hB00, 1'b0, '0, '0); settle();
      tick(); idle_inputs();
      lsu_resp(32'h77777777, 1'b0);
      req0(30'hC00, 1'b0, '0, '0); settle();
      chk("t6_rsp_sn0", 64'(rq0_stall_next), 64'd0);
      chk("t6_rsp_ps", 64'(lsu_prev_stalled), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t6_next_ps", 64'(lsu_prev_stalled), 64'd0);
      chk("t6_next_addr", 64'(lsu_addr), 64'hC00);
      chk("t6_err", 64'(protocol_err), 64'd0);
      tick();
      lsu_resp(32'h0, 1'b0); settle();
      chk("t6_next_sn0", 64'(rq0_stall_next), 64'd0);
      tick(); idle_inputs();

      // rq0 re-requests before its response
      req0(30'hD00, 1'b0, '0, '0); settle();
      tick(); idle_inputs();
      req0(30'hD40, 1'b0, '0, '0); settle();
      tick(); idle_inputs(); settle();
      chk("t7_rereq_err", 64'(protocol_err), 64'd1);
      lsu_resp(32'h0, 1'b0); settle();
      chk("t7_rsp_sn0", 64'(rq0_stall_next), 64'd0);
      tick(); idle_inputs(); settle();
      chk("t7_dropped", 64'(lsu_prev_stalled), 64'd1);

      // Spurious LSU response while IDLE
      rst_n = 1'b0;
      tick(); rst_n = 1'b1; settle();
      chk("t8_err_clr", 64'(protocol_err), 64'd0);
      lsu_resp(32'h88888888, 1'b0); settle();
      chk("t8_sp_sn0", 64'(rq0_stall_next), 64'd1);
      chk("t8_sp_sn1", 64'(rq1_stall_next), 64'd1);
      tick(); idle_inputs(); settle();
      chk("t8_sp_err", 64'(protocol_err), 64'd1);
      tick(); tick(); settle();
      chk("t8_sp_sticky", 64'(protocol_err), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
